// File: rtl/scan_sel_seq_pkg.sv
// Shared constants and state encoding for the scan-select sequencer.
package scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_next_ch.sv
// Circular priority finder: lowest enabled channel above cur, else lowest enabled overall.
// Driving cur with the top index makes it return the lowest set bit of the mask.
module scan_next_ch
    import scan_pkg::*;
(
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  next,
    output logic              wrap,
    output logic              none
);

    logic              hi_found_s;
    logic [SEL_W-1:0]  hi_idx_s;
    logic [SEL_W-1:0]  lo_idx_s;

    // Scan from the top down so the last hit is the lowest qualifying index.
    always_comb begin
        hi_found_s = 1'b0;
        hi_idx_s   = {SEL_W{1'b0}};
        lo_idx_s   = {SEL_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                lo_idx_s = SEL_W'(i);
                if (SEL_W'(i) > cur) begin
                    hi_found_s = 1'b1;
                    hi_idx_s   = SEL_W'(i);
                end else begin
                    hi_found_s = hi_found_s;
                end
            end else begin
                lo_idx_s = lo_idx_s;
            end
        end
    end

    // Pick the higher channel when one exists, otherwise wrap around.
    always_comb begin
        if (hi_found_s) begin
            next = hi_idx_s;
        end else begin
            next = lo_idx_s;
        end
        wrap = ~hi_found_s;
        none = ~(|ch_mask);
    end

endmodule

// File: rtl/scan_sel_seq.sv
// Steps a 3-bit decoder select through the enabled channels, holding each for a
// programmable dwell followed by one blanking cycle.
module scan_sel_seq
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               single,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   ABC,
    output logic               sel_valid,
    output logic               frame_done,
    output logic               busy
);

    localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

    scan_state_t        state_r;
    logic [SEL_W-1:0]   abc_r;
    logic               sel_valid_r;
    logic               frame_done_r;
    logic               busy_r;
    logic [DWELL_W-1:0] cnt_r;
    logic [DWELL_W-1:0] dwell_r;
    logic               single_r;

    logic [SEL_W-1:0]   cur_s;
    logic [SEL_W-1:0]   next_s;
    logic               wrap_s;
    logic               none_s;

    // In IDLE the finder searches from "before channel 0" to get the first channel.
    always_comb begin
        if (state_r == IDLE) begin
            cur_s = {SEL_W{1'b1}};
        end else begin
            cur_s = abc_r;
        end
    end

    scan_next_ch u_next_ch (
        .ch_mask (ch_mask),
        .cur     (cur_s),
        .next    (next_s),
        .wrap    (wrap_s),
        .none    (none_s)
    );

    // Sequencer state, dwell counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            abc_r        <= {SEL_W{1'b0}};
            sel_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
            cnt_r        <= CNT_ZERO;
            dwell_r      <= CNT_ZERO;
            single_r     <= 1'b0;
        end else if (stop) begin
            state_r      <= IDLE;
            sel_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
            cnt_r        <= CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !none_s) begin
                        state_r     <= DWELL;
                        abc_r       <= next_s;
                        dwell_r     <= dwell;
                        single_r    <= single;
                        cnt_r       <= CNT_ZERO;
                        sel_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DWELL: begin
                    if (cnt_r == dwell_r) begin
                        // frame_done must be visible during BLANK, so predict the wrap here.
                        state_r      <= BLANK;
                        cnt_r        <= CNT_ZERO;
                        sel_valid_r  <= 1'b0;
                        frame_done_r <= wrap_s & ~none_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                BLANK: begin
                    frame_done_r <= 1'b0;
                    if (none_s || (wrap_s && single_r)) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r     <= DWELL;
                        abc_r       <= next_s;
                        sel_valid_r <= 1'b1;
                        if (!wrap_s) begin
                            dwell_r <= dwell;
                        end else begin
                            dwell_r <= dwell_r;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    sel_valid_r  <= 1'b0;
                    frame_done_r <= 1'b0;
                    busy_r       <= 1'b0;
                    cnt_r        <= CNT_ZERO;
                end
            endcase
        end
    end

    assign ABC        = abc_r;
    assign sel_valid  = sel_valid_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_scan_sel_seq.sv
// Directed bench for scan_sel_seq: expected per-cycle outputs are queued with the
// stimulus and popped on each falling edge.
module tb_scan_sel_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       single;
    logic [7:0] ch_mask;
    logic [7:0] dwell;
    logic [2:0] ABC;
    logic       sel_valid;
    logic       frame_done;
    logic       busy;

    typedef struct {
        logic [2:0] abc;
        logic       sv;
        logic       fd;
        logic       busy;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string tag    = "none";

    scan_sel_seq #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .single     (single),
        .ch_mask    (ch_mask),
        .dwell      (dwell),
        .ABC        (ABC),
        .sel_valid  (sel_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check_out(input logic [2:0] a, input logic v, input logic f, input logic b);
        checks++;
        assert ((ABC === a) && (sel_valid === v) && (frame_done === f) && (busy === b)) else begin
            errors++;
            $error("FAIL %s: got abc=%0d sel_valid=%0b frame_done=%0b busy=%0b, expected abc=%0d sel_valid=%0b frame_done=%0b busy=%0b",
                   tag, ABC, sel_valid, frame_done, busy, a, v, f, b);
        end
    endtask

    task automatic push_exp(input logic [2:0] a, input logic v, input logic f, input logic b);
        exp_t e;
        e.abc  = a;
        e.sv   = v;
        e.fd   = f;
        e.busy = b;
        exp_q.push_back(e);
    endtask

    task automatic push_dwell(input logic [2:0] ch, input int n);
        for (int i = 0; i < n; i++) push_exp(ch, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic push_blank(input logic [2:0] ch, input logic fd);
        push_exp(ch, 1'b0, fd, 1'b1);
    endtask

    task automatic push_idle(input logic [2:0] ch, input int n);
        for (int i = 0; i < n; i++) push_exp(ch, 1'b0, 1'b0, 1'b0);
    endtask

    // One sweep over the set bits of mask; the blank after the highest channel carries frame_done.
    task automatic push_frame(input logic [7:0] mask, input int dw);
        int last;
        last = 0;
        for (int i = 0; i < 8; i++) if (mask[i]) last = i;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                push_dwell(3'(i), dw + 1);
                push_blank(3'(i), (i == last));
            end
        end
    endtask

    task automatic tick_check();
        exp_t e;
        @(negedge clk);
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s: scoreboard empty, got abc=%0d sel_valid=%0b, expected a queued entry", tag, ABC, sel_valid);
        end
        if (exp_q.size() != 0) begin
            checks--;
            e = exp_q.pop_front();
            check_out(e.abc, e.sv, e.fd, e.busy);
        end
    endtask

    task automatic drain();
        while (exp_q.size() != 0) tick_check();
    endtask

    task automatic start_scan(input logic [7:0] mask, input logic [7:0] dw, input logic sgl);
        ch_mask = mask;
        dwell   = dw;
        single  = sgl;
        start   = 1'b1;
        tick_check();
        start   = 1'b0;
        drain();
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        single  = 1'b0;
        ch_mask = 8'h00;
        dwell   = 8'd0;

        tag = "reset";
        repeat (3) @(negedge clk);
        check_out(3'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        push_idle(3'd0, 5);
        drain();

        // Continuous: two full frames of 16 cycles, then stop two cycles into ch 0.
        tag = "continuous";
        push_frame(8'b1010_0101, 2);
        push_frame(8'b1010_0101, 2);
        push_dwell(3'd0, 2);
        start_scan(8'b1010_0101, 8'd2, 1'b0);
        tag = "stop_dwell";
        stop = 1'b1;
        push_idle(3'd0, 1);
        tick_check();
        stop = 1'b0;
        push_idle(3'd0, 2);
        drain();

        tag = "single_sweep";
        push_frame(8'b0001_1000, 0);
        push_idle(3'd4, 3);
        start_scan(8'b0001_1000, 8'd0, 1'b1);

        tag = "mask_change";
        push_dwell(3'd0, 4);
        push_blank(3'd0, 1'b0);
        push_dwell(3'd1, 4);
        push_blank(3'd1, 1'b0);
        push_dwell(3'd2, 2);
        start_scan(8'hFF, 8'd3, 1'b0);
        ch_mask = 8'b1000_0001;
        push_dwell(3'd2, 2);
        push_blank(3'd2, 1'b0);
        push_dwell(3'd7, 4);
        push_blank(3'd7, 1'b1);
        push_dwell(3'd0, 4);
        push_blank(3'd0, 1'b0);
        drain();
        tag = "stop_blank";
        stop = 1'b1;
        push_idle(3'd0, 1);
        tick_check();
        stop = 1'b0;

        tag = "start_mask0";
        ch_mask = 8'h00;
        start   = 1'b1;
        push_idle(3'd0, 3);
        drain();
        tag = "start_and_stop";
        ch_mask = 8'hFF;
        stop    = 1'b1;
        push_idle(3'd0, 2);
        drain();
        start = 1'b0;
        stop  = 1'b0;
        push_idle(3'd0, 1);
        drain();

        tag = "async_reset";
        push_dwell(3'd4, 3);
        start_scan(8'b0011_0000, 8'd5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out(3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(3'd0, 2);
        drain();

        // Single channel, maximum dwell: 256 valid cycles then a wrap blank, period 257.
        tag = "dwell_max";
        push_dwell(3'd6, 256);
        push_blank(3'd6, 1'b1);
        push_dwell(3'd6, 256);
        push_blank(3'd6, 1'b1);
        push_dwell(3'd6, 2);
        start_scan(8'b0100_0000, 8'd255, 1'b0);
        stop = 1'b1;
        push_idle(3'd6, 1);
        tick_check();
        stop = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
